vtree_feed_sched: RTL and testbench

- Input scheduler for the virtual merge-sorter tree (vMERGE_SORTER_TREE).
- Decides each cycle which of the 2^W_LOG ways receives the next 2^P_LOG-record block. Drives the tree's DIN_IDX/DINEN.
- Pops per-way source buffers and injects one terminal (all-ones key) block per way once that way's run is exhausted.
- Sequences one merge pass: in-order initial fill, round-robin refill, completion.

---
 rtl/vtree_feed_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_vtree_feed_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtree_feed_sched.sv
// vtree_feed_sched -- input scheduler for the virtual merge-sorter tree.
//
// Picks, each cycle, which of the 2^W_LOG ways gets the next record block.
// One pass has three phases:
//   - INIT: every way gets one block, strictly in order.
//   - RUN: round-robin refill of ways whose tree buffer is empty. Once a
//     way's run of BLKS blocks is used up, it gets a single terminal block.
//   - DONE: a one-cycle PASS_DONE pulse.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START, BLKS         begin a pass with BLKS blocks per way (IDLE only, BLKS!=0)
//   IN_FULL             downstream back-pressure, suppresses the grant
//   EMP[N]              per-way tree buffer empty
//   SRC_VLD[N]          per-way source block available
//   DINEN, DIN_IDX      registered grant strobe and way index
//   DIN_TERM            the granted block is the terminal (all-ones key) block
//   SRC_DEQ[N]          one-hot source pop, never together with DIN_TERM
//   BUSY, PASS_DONE     pass in progress / end-of-pass pulse
//
// Optional: define VTREE_SCHED_STAT_EN to add the STALL_CNT and FULL_CNT
// saturating statistics counters.

// Per-way state: the count of source blocks sent, the terminal-sent flag,
// and the post-grant hold timer. The hold timer masks the way until the
// tree's EMP flag reflects the block that was just pushed.
module vtree_feed_way #(
  parameter int BLKW     = 32,
  parameter int HOLD_CYC = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clr,
  input  logic            gnt,
  input  logic [BLKW-1:0] blks,
  input  logic            emp,
  input  logic            src_vld,
  output logic            cand,
  output logic            exh,
  output logic            term
);
  logic [2:0]      hold;
  logic [BLKW-1:0] cnt;

  assign exh  = (cnt == blks);
  assign cand = emp & (hold == 3'd0) & ~term & (exh | src_vld);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      hold <= '0;
      term <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      hold <= '0;
      term <= 1'b0;
    end else if (gnt) begin
      hold <= 3'(HOLD_CYC);
      // An exhausted way takes its terminal block, so cnt stops at blks.
      if (exh) term <= 1'b1;
      else     cnt  <= cnt + BLKW'(1);
    end else if (hold != 3'd0) begin
      hold <= hold - 3'd1;
    end
  end
endmodule

module vtree_feed_sched #(
  parameter int W_LOG    = 4,
  parameter int BLKW     = 32,
  parameter int HOLD_CYC = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BLKW-1:0]       BLKS,
  input  logic                  IN_FULL,
  input  logic [(1<<W_LOG)-1:0] EMP,
  input  logic [(1<<W_LOG)-1:0] SRC_VLD,
  output logic                  DINEN,
  output logic [W_LOG-1:0]      DIN_IDX,
  output logic                  DIN_TERM,
  output logic [(1<<W_LOG)-1:0] SRC_DEQ,
  output logic                  BUSY,
  output logic                  PASS_DONE
`ifdef VTREE_SCHED_STAT_EN
  ,
  output logic [31:0]           STALL_CNT,
  output logic [31:0]           FULL_CNT
`endif
);
  localparam int N = 1 << W_LOG;

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_d;
  logic [W_LOG-1:0] idx, idx_d, rr, rr_d, gnt_w;
  logic [BLKW-1:0]  blks_q;
  logic [N-1:0]     cand, exh, term, gnt_vec;
  logic [W_LOG:0]   pick;
  logic             clr, gnt, gnt_term, pass_d;

  // Returns {found, way}: the first candidate at or after p, wrapping around.
  // The loop runs downward, so the smallest offset is the last assignment
  // and wins.
  function automatic logic [W_LOG:0] rr_pick(input logic [N-1:0] c, input logic [W_LOG-1:0] p);
    logic [W_LOG-1:0] w;
    rr_pick = '0;
    for (int i = N-1; i >= 0; i--) begin
      w = p + W_LOG'(i);
      if (c[w]) rr_pick = {1'b1, w};
    end
  endfunction

  assign pick = rr_pick(cand, rr);

  for (genvar w = 0; w < N; w++) begin : g_way
    vtree_feed_way #(.BLKW(BLKW), .HOLD_CYC(HOLD_CYC)) u_way (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (clr),
      .gnt     (gnt_vec[w]),
      .blks    (blks_q),
      .emp     (EMP[w]),
      .src_vld (SRC_VLD[w]),
      .cand    (cand[w]),
      .exh     (exh[w]),
      .term    (term[w])
    );
  end

  always_comb begin
    gnt_vec = '0;
    if (gnt) gnt_vec[gnt_w] = 1'b1;
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    rr_d     = rr;
    clr      = 1'b0;
    gnt      = 1'b0;
    gnt_w    = '0;
    gnt_term = 1'b0;
    pass_d   = 1'b0;
    case (state)
      IDLE: if (START && (BLKS != '0)) begin
        clr     = 1'b1;
        idx_d   = '0;
        state_d = INIT;
      end
      // EMP is deliberately ignored here: every tree buffer starts empty.
      INIT: if (SRC_VLD[idx] && !IN_FULL) begin
        gnt   = 1'b1;
        gnt_w = idx;
        if (idx == W_LOG'(N-1)) begin
          state_d = RUN;
          rr_d    = '0;
        end else begin
          idx_d = idx + W_LOG'(1);
        end
      end
      RUN: begin
        // Finish only after the last terminal strobe has left the register.
        if ((&term) && !DINEN) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (!IN_FULL && pick[W_LOG]) begin
          gnt      = 1'b1;
          gnt_w    = pick[W_LOG-1:0];
          gnt_term = exh[pick[W_LOG-1:0]];
          rr_d     = pick[W_LOG-1:0] + W_LOG'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      rr        <= '0;
      blks_q    <= '0;
      DINEN     <= 1'b0;
      DIN_IDX   <= '0;
      DIN_TERM  <= 1'b0;
      SRC_DEQ   <= '0;
      BUSY      <= 1'b0;
      PASS_DONE <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      rr        <= rr_d;
      if (clr) blks_q <= BLKS;
      DINEN     <= gnt;
      DIN_IDX   <= gnt ? gnt_w : '0;
      DIN_TERM  <= gnt & gnt_term;
      SRC_DEQ   <= (gnt && !gnt_term) ? gnt_vec : '0;
      BUSY      <= (state_d != IDLE);
      PASS_DONE <= pass_d;
    end
  end

`ifdef VTREE_SCHED_STAT_EN
  logic stall;
  assign stall = ((state == INIT) || (state == RUN)) && !gnt && !(&term);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STALL_CNT <= '0;
      FULL_CNT  <= '0;
    end else if (clr) begin
      STALL_CNT <= '0;
      FULL_CNT  <= '0;
    end else begin
      if (stall && (STALL_CNT != '1))           STALL_CNT <= STALL_CNT + 32'd1;
      if (IN_FULL && BUSY && (FULL_CNT != '1))  FULL_CNT  <= FULL_CNT + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vtree_feed_sched.sv
// Bench for vtree_feed_sched (W_LOG=2, HOLD_CYC=3). It combines:
//   - a per-cycle vector table for a minimal pass,
//   - directed multi-cycle sequences for the corner cases,
//   - a randomized run checked against a behavioural model that keeps
//     per-way sent counts and "eligible from cycle" timestamps.
module tb_vtree_feed_sched;
  localparam int W_LOG = 2;
  localparam int N     = 4;
  localparam int BLKW  = 32;
  localparam int HOLD  = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [BLKW-1:0]  BLKS = '0;
  logic             IN_FULL = 1'b0;
  logic [N-1:0]     EMP = '1;
  logic [N-1:0]     SRC_VLD = '1;
  logic             DINEN, DIN_TERM, BUSY, PASS_DONE;
  logic [W_LOG-1:0] DIN_IDX;
  logic [N-1:0]     SRC_DEQ;

  vtree_feed_sched #(.W_LOG(W_LOG), .BLKW(BLKW), .HOLD_CYC(HOLD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BLKS(BLKS), .IN_FULL(IN_FULL),
    .EMP(EMP), .SRC_VLD(SRC_VLD), .DINEN(DINEN), .DIN_IDX(DIN_IDX),
    .DIN_TERM(DIN_TERM), .SRC_DEQ(SRC_DEQ), .BUSY(BUSY), .PASS_DONE(PASS_DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int n_din = 0, n_term = 0, n_pass = 0, last_gnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (DINEN) begin
      n_din++;
      last_gnt = int'(DIN_IDX);
      if (DIN_TERM) n_term++;
    end
    if (PASS_DONE) n_pass++;
  endtask

  task automatic clr_cnt();
    n_din = 0; n_term = 0; n_pass = 0;
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_ph, m_idx, m_rr, m_blks, mt;
  int           m_sent[N];
  bit           m_term[N];
  int           m_rdy[N];
  bit           e_din, e_term, e_busy, e_pass;
  int           e_idx;
  logic [N-1:0] e_deq;

  task automatic m_reset();
    m_ph = 0; m_idx = 0; m_rr = 0; m_blks = 0; mt = 0;
    for (int w = 0; w < N; w++) begin m_sent[w] = 0; m_term[w] = 0; m_rdy[w] = 0; end
    e_din = 0; e_term = 0; e_busy = 0; e_pass = 0; e_idx = 0; e_deq = '0;
  endtask

  // Decide this cycle from the current inputs. The e_* values are what the
  // DUT must show after the next rising edge.
  task automatic m_step();
    bit g = 0, gt = 0, alltm = 1, cur = e_din;
    int gw = 0;
    mt++;
    e_pass = 0;
    case (m_ph)
      0: if (START && BLKS != 0) begin
        m_blks = int'(BLKS);
        for (int w = 0; w < N; w++) begin m_sent[w] = 0; m_term[w] = 0; m_rdy[w] = 0; end
        m_idx = 0; m_ph = 1;
        clr_cnt();
      end
      1: if (SRC_VLD[m_idx] && !IN_FULL) begin
        g = 1; gw = m_idx;
        if (m_idx == N-1) begin m_ph = 2; m_rr = 0; end
        else m_idx++;
      end
      2: begin
        for (int w = 0; w < N; w++) alltm &= m_term[w];
        if (alltm && !cur) begin
          m_ph = 3; e_pass = 1;
        end else if (!IN_FULL) begin
          for (int k = 0; k < N && !g; k++) begin
            int w = (m_rr + k) % N;
            bit ex = (m_sent[w] == m_blks);
            if (EMP[w] && mt >= m_rdy[w] && !m_term[w] && (ex || SRC_VLD[w])) begin
              g = 1; gw = w; gt = ex;
            end
          end
          if (g) m_rr = (gw + 1) % N;
        end
      end
      default: m_ph = 0;
    endcase
    if (g) begin
      m_rdy[gw] = mt + HOLD + 1;
      if (gt) m_term[gw] = 1;
      else    m_sent[gw]++;
    end
    e_din  = g;
    e_idx  = gw;
    e_term = gt;
    e_deq  = (g && !gt) ? 4'(1 << gw) : 4'b0;
    e_busy = (m_ph != 0);
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    RST = 1; START = 0; IN_FULL = 0; BLKS = '0; EMP = '1; SRC_VLD = '1;
    tick(); tick();
    RST = 0;
    m_reset();
    clr_cnt();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!PASS_DONE && k < budget) begin tick(); k++; end
    chk("pass_done_seen", PASS_DONE, 1);
    tick();
    chk("idle_after_done", {BUSY, PASS_DONE}, 2'b00);
  endtask

  typedef struct {
    logic        start;
    logic [31:0] blks;
    logic        busy, din;
    logic [1:0]  idx;
    logic        term;
    logic [3:0]  deq;
    logic        pass;
  } vec_t;

  function automatic vec_t mkv(logic s, logic [31:0] b, logic bu, logic d, logic [1:0] i,
                               logic t, logic [3:0] q, logic p);
    vec_t v;
    v.start = s; v.blks = b; v.busy = bu; v.din = d; v.idx = i; v.term = t; v.deq = q; v.pass = p;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic t_table();
    vec_t tbl[14];
    // Inputs are held at EMP=1111, SRC_VLD=1111, IN_FULL=0 throughout.
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 4'b0000, 0); // BLKS=0 ignored
    tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[2]  = mkv(1, 1, 1, 0, 0, 0, 4'b0000, 0); // accepted, INIT
    tbl[3]  = mkv(0, 0, 1, 1, 0, 0, 4'b0001, 0);
    tbl[4]  = mkv(0, 0, 1, 1, 1, 0, 4'b0010, 0);
    tbl[5]  = mkv(0, 0, 1, 1, 2, 0, 4'b0100, 0);
    tbl[6]  = mkv(0, 0, 1, 1, 3, 0, 4'b1000, 0);
    tbl[7]  = mkv(0, 0, 1, 1, 0, 1, 4'b0000, 0); // terminal blocks
    tbl[8]  = mkv(0, 0, 1, 1, 1, 1, 4'b0000, 0);
    tbl[9]  = mkv(0, 0, 1, 1, 2, 1, 4'b0000, 0);
    tbl[10] = mkv(0, 0, 1, 1, 3, 1, 4'b0000, 0);
    tbl[11] = mkv(0, 0, 1, 0, 0, 0, 4'b0000, 0);
    tbl[12] = mkv(0, 0, 1, 0, 0, 0, 4'b0000, 1); // DONE
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    do_reset();
    chk("reset_outputs", {BUSY, DINEN, DIN_IDX, DIN_TERM, SRC_DEQ, PASS_DONE}, 10'd0);
    for (int i = 0; i < 14; i++) begin
      START = tbl[i].start; BLKS = tbl[i].blks;
      tick();
      chk($sformatf("tbl%0d", i),
          {BUSY, DINEN, (DINEN ? DIN_IDX : 2'b00), DINEN & DIN_TERM, SRC_DEQ, PASS_DONE},
          {tbl[i].busy, tbl[i].din, tbl[i].idx, tbl[i].term, tbl[i].deq, tbl[i].pass});
    end
    chk("tbl_total_din", n_din, 8);
    chk("tbl_total_term", n_term, 4);
    chk("tbl_pass_once", n_pass, 1);
  endtask

  task automatic t_hold();
    int prev2 = -100, run_g = 0, bad = 0, mingap = 1000;
    do_reset();
    EMP = 4'b0100; START = 1; BLKS = 3;
    tick();
    START = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (DINEN) begin
        if (k >= 4) begin
          run_g++;
          if (DIN_IDX != 2) bad++;
        end
        if (DIN_IDX == 2) begin
          if (k - prev2 < mingap) mingap = k - prev2;
          prev2 = k;
        end
      end
    end
    chk("hold_other_way", bad, 0);
    chk("hold_run_grants", run_g, 3);
    chk("hold_gap_ge4", mingap >= 4, 1);
    EMP = '1;
    wait_done(200);
    chk("hold_total_din", n_din, 16);
    chk("hold_total_term", n_term, 4);
  endtask

  task automatic t_init_stall();
    do_reset();
    SRC_VLD = 4'b1101; START = 1; BLKS = 1;
    tick();
    START = 0;
    tick();
    chk("stall_first", {DINEN, DIN_IDX}, {1'b1, 2'd0});
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold", DINEN, 0);
    end
    SRC_VLD = '1;
    tick(); chk("stall_resume1", {DINEN, DIN_IDX}, {1'b1, 2'd1});
    tick(); chk("stall_resume2", {DINEN, DIN_IDX}, {1'b1, 2'd2});
    tick(); chk("stall_resume3", {DINEN, DIN_IDX}, {1'b1, 2'd3});
    wait_done(100);
    chk("stall_total_din", n_din, 8);
  endtask

  task automatic t_full();
    int seen = 0;
    do_reset();
    START = 1; BLKS = 3;
    tick();
    START = 0;
    repeat (6) tick();
    chk("full_pre_idx", last_gnt, 1);
    IN_FULL = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (DINEN) seen++;
    end
    chk("full_no_grant", seen, 0);
    IN_FULL = 0;
    tick();
    chk("full_resume_rr", {DINEN, DIN_IDX}, {1'b1, 2'd2});
    wait_done(200);
    chk("full_total_din", n_din, 16);
  endtask

  task automatic t_reset_mid();
    do_reset();
    START = 1; BLKS = 3;
    tick();
    START = 0;
    repeat (7) tick();
    chk("pre_rst_active", {BUSY, DINEN}, 2'b11);
    RST = 1;
    #1;
    chk("rst_async", {BUSY, DINEN, DIN_TERM, SRC_DEQ, PASS_DONE}, 8'd0);
    tick();
    chk("rst_held", {BUSY, DINEN, DIN_TERM, SRC_DEQ, PASS_DONE}, 8'd0);
    RST = 0;
    m_reset();
    clr_cnt();
    START = 1; BLKS = 2;
    tick();
    START = 0;
    wait_done(200);
    chk("rst_new_total_din", n_din, 12);
    chk("rst_new_total_term", n_term, 4);
    chk("rst_new_pass_once", n_pass, 1);
  endtask

  task automatic t_random(input int cycles);
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      START   = ($urandom % 8) == 0;
      BLKS    = $urandom % 4;
      IN_FULL = ($urandom % 5) == 0;
      EMP     = ~(4'($urandom) & 4'($urandom));
      SRC_VLD = ~(4'($urandom) & 4'($urandom));
      m_step();
      tick();
      chk("rnd_busy", BUSY, e_busy);
      chk("rnd_dinen", DINEN, e_din);
      chk("rnd_pass", PASS_DONE, e_pass);
      chk("rnd_deq", SRC_DEQ, e_deq);
      if (e_din) begin
        chk("rnd_idx", DIN_IDX, e_idx);
        chk("rnd_term", DIN_TERM, e_term);
      end
      if (e_pass && PASS_DONE) begin
        chk("rnd_pass_din", n_din, N * (m_blks + 1));
        chk("rnd_pass_term", n_term, N);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_table();
    t_hold();
    t_init_stall();
    t_full();
    t_reset_mid();
    t_random(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
